// File: rtl/pingpong_route_ctrl.sv
// pingpong_route_ctrl: write-side scheduler that steers whole frames into a ping-pong buffer pair.
// Optional abort port is compiled in when PINGPONG_ABORT_EN is defined.

module demux_1to2 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] din,
  input  logic             sel,
  output logic [WIDTH-1:0] dout_0,
  output logic [WIDTH-1:0] dout_1
);

  always_comb begin
    dout_0 = sel ? '0 : din;
    dout_1 = sel ? din : '0;
  end

endmodule

module pingpong_route_ctrl #(
  parameter int WORD_SIZE   = 16,
  parameter int FRAME_WORDS = 784,
  parameter int ADDR_W      = $clog2(FRAME_WORDS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic [WORD_SIZE-1:0] in_data,
  output logic                 in_ready,
  input  logic [1:0]           buf_release,
  output logic [WORD_SIZE-1:0] wr_data_0,
  output logic [WORD_SIZE-1:0] wr_data_1,
  output logic                 wr_en_0,
  output logic                 wr_en_1,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [1:0]           buf_full,
  output logic                 frame_done
`ifdef PINGPONG_ABORT_EN
  ,
  input  logic                 abort
`endif
);

  logic                 sel;
  logic                 sel_q;
  logic [ADDR_W-1:0]    cnt;
  logic [WORD_SIZE-1:0] data_q;
  logic                 accept;
  logic                 take;
  logic                 last;
  logic                 abort_i;
  logic [1:0]           set_mask;

`ifdef PINGPONG_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  assign in_ready = ~buf_full[sel];
  assign accept   = in_valid & in_ready;
  // An abort swallows any word handshaken in the same cycle.
  assign take     = accept & ~abort_i;
  assign last     = (cnt == ADDR_W'(FRAME_WORDS - 1));
  assign set_mask = (take & last) ? (sel ? 2'b10 : 2'b01) : 2'b00;

  // A completing buffer was not full, so a same-cycle release to it cannot clear the new set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel        <= 1'b0;
      sel_q      <= 1'b0;
      cnt        <= '0;
      data_q     <= '0;
      wr_addr    <= '0;
      wr_en_0    <= 1'b0;
      wr_en_1    <= 1'b0;
      frame_done <= 1'b0;
      buf_full   <= 2'b00;
    end else begin
      buf_full   <= (buf_full & ~buf_release) | set_mask;
      wr_en_0    <= take & ~sel;
      wr_en_1    <= take & sel;
      frame_done <= take & last;
      if (abort_i) begin
        cnt <= '0;
      end else if (take) begin
        data_q  <= in_data;
        sel_q   <= sel;
        wr_addr <= cnt;
        if (last) begin
          cnt <= '0;
          sel <= ~sel;
        end else begin
          cnt <= cnt + ADDR_W'(1);
        end
      end
    end
  end

  demux_1to2 #(
    .WIDTH(WORD_SIZE)
  ) u_demux (
    .din   (data_q),
    .sel   (sel_q),
    .dout_0(wr_data_0),
    .dout_1(wr_data_1)
  );

endmodule
